// File: rtl/instr_sequencer.sv
// Basic-computer control unit: tracks fetch/indirect/execute/halt and decodes (state, T-step, IR)
// into one-cycle datapath strobes; strobes are combinational, state changes on posedge clk.
module instr_sequencer #(
  parameter logic [2:0] HALT_OPC     = 3'b111,
  parameter bit         AUTO_RESTART = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [3:0] t,
  input  logic [2:0] ir_opcode,
  input  logic       ir_i,
  input  logic       dr_zero,
  output logic       sc_clr,
  output logic       ar_ld,
  output logic [1:0] ar_src,
  output logic       ar_inc,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic       ir_ld,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_src,
  output logic       dr_ld,
  output logic       dr_inc,
  output logic       ac_ld,
  output logic [1:0] alu_op,
  output logic       done,
  output logic       busy,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_INDIRECT = 3'd2,
    S_EXECUTE  = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   t_ok;
  logic   exec_last;

  // A corrupted timing counter (zero or multi-hot) must never fire a strobe.
  assign t_ok = (t != 4'b0000) && ((t & (t - 4'd1)) == 4'b0000);

  // Final T-step of each instruction's execute phase.
  always_comb begin
    exec_last = 1'b0;
    case (ir_opcode)
      3'b000, 3'b001, 3'b010: exec_last = t[1];
      3'b011, 3'b100:         exec_last = t[0];
      3'b101:                 exec_last = t[1];
      3'b110:                 exec_last = t[2];
      default:                exec_last = t[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (t_ok && t[3]) begin
          if (ir_opcode == HALT_OPC) state_d = S_HALT;
          else if (ir_i)             state_d = S_INDIRECT;
          else                       state_d = S_EXECUTE;
        end
      end
      S_INDIRECT: if (t_ok && t[0]) state_d = S_EXECUTE;
      S_EXECUTE:  if (t_ok && exec_last) state_d = S_FETCH;
      S_HALT:     if (AUTO_RESTART && start) state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q == S_FETCH) || (state_q == S_INDIRECT) || (state_q == S_EXECUTE);
  assign halted = (state_q == S_HALT);

  always_comb begin
    sc_clr  = 1'b0;
    ar_ld   = 1'b0;
    ar_src  = 2'd0;
    ar_inc  = 1'b0;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    ir_ld   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    mem_src = 1'b0;
    dr_ld   = 1'b0;
    dr_inc  = 1'b0;
    ac_ld   = 1'b0;
    alu_op  = 2'd0;
    done    = 1'b0;
    if (clr || !busy || !t_ok) begin
      sc_clr = 1'b1;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (t[0]) ar_ld = 1'b1;
          if (t[1]) begin
            mem_rd = 1'b1;
            ir_ld  = 1'b1;
            pc_inc = 1'b1;
          end
          if (t[2]) begin
            ar_ld  = 1'b1;
            ar_src = 2'd1;
          end
        end
        S_INDIRECT: begin
          if (t[0]) begin
            mem_rd = 1'b1;
            ar_ld  = 1'b1;
            ar_src = 2'd2;
            sc_clr = 1'b1;
          end
        end
        S_EXECUTE: begin
          case (ir_opcode)
            3'b000, 3'b001, 3'b010: begin
              if (t[0]) begin
                mem_rd = 1'b1;
                dr_ld  = 1'b1;
              end
              if (t[1]) begin
                ac_ld  = 1'b1;
                alu_op = ir_opcode[1:0];
              end
            end
            3'b011: if (t[0]) mem_wr = 1'b1;
            3'b100: if (t[0]) pc_ld = 1'b1;
            3'b101: begin
              if (t[0]) begin
                mem_wr  = 1'b1;
                mem_src = 1'b1;
                ar_inc  = 1'b1;
              end
              if (t[1]) pc_ld = 1'b1;
            end
            3'b110: begin
              if (t[0]) begin
                mem_rd = 1'b1;
                dr_ld  = 1'b1;
              end
              if (t[1]) dr_inc = 1'b1;
              if (t[2]) begin
                mem_wr = 1'b1;
                pc_inc = dr_zero;
              end
            end
            default: ;
          endcase
          if (exec_last) begin
            sc_clr = 1'b1;
            done   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
